// File: rtl/dram_arb_pkg.sv
// Shared defaults and index/count types for the DRAM port arbiter.
package dram_arb_pkg;

  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned AW_DEF       = 32;
  localparam int unsigned DW_DEF       = 64;
  localparam int unsigned ID_DEPTH_DEF = 8;

  localparam int unsigned ID_W  = $clog2(N_REQ_DEF);
  localparam int unsigned CNT_W = $clog2(ID_DEPTH_DEF) + 1;

  typedef logic [ID_W-1:0]  req_id_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dram_port_arbiter_rr_grant.sv
// Round-robin grant: first requester after ptr wins; one-hot grant plus encoded id.
module rr_grant #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic           en,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IDW'((32'(ptr) + i) % N);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares DRAM read-address/read-data/write channels among N_REQ requesters.
// Write arbiter is built only when DRAM_ARB_WRITE_EN is defined.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned ID_DEPTH = ID_DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_ra_rdy,
  output logic [N_REQ-1:0]         o_ra_ack,
  input  logic [N_REQ-1:0][AW-1:0] i_ra_addr,
  output logic [N_REQ-1:0]         o_rd_rdy,
  input  logic [N_REQ-1:0]         i_rd_ack,
  output logic [DW-1:0]            o_rd_data,
  output logic                     o_dramra_rdy,
  input  logic                     i_dramra_ack,
  output logic [AW-1:0]            o_dramra_addr,
  input  logic                     i_dramrd_rdy,
  output logic                     o_dramrd_ack,
  input  logic [DW-1:0]            i_dramrd_data,
  input  logic [N_REQ-1:0]         i_w_rdy,
  output logic [N_REQ-1:0]         o_w_ack,
  input  logic [N_REQ-1:0][AW-1:0] i_w_addr,
  input  logic [N_REQ-1:0][DW-1:0] i_w_data,
  output logic                     o_dramw_rdy,
  input  logic                     i_dramw_ack,
  output logic [AW-1:0]            o_dramw_addr,
  output logic [DW-1:0]            o_dramw_data
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned PW  = $clog2(ID_DEPTH);
  localparam int unsigned CW  = PW + 1;

  // ---------------- read-address arbiter ----------------
  logic           ra_vld;
  logic [AW-1:0]  ra_addr_q;
  logic [IDW-1:0] ra_ptr;
  logic [CW-1:0]  rd_cnt;
  logic           ra_free;
  logic           ra_en;
  logic [IDW-1:0] ra_gid;

  // Full is judged on the registered count so a pop cannot free a slot combinationally.
  assign ra_free = !ra_vld || i_dramra_ack;
  assign ra_en   = ra_free && (rd_cnt < CW'(ID_DEPTH)) && (|i_ra_rdy);

  rr_grant #(.N(N_REQ), .IDW(IDW)) u_ra_rr (
    .req    (i_ra_rdy),
    .en     (ra_en),
    .ptr    (ra_ptr),
    .gnt    (o_ra_ack),
    .gnt_id (ra_gid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ra_vld    <= 1'b0;
      ra_addr_q <= '0;
      ra_ptr    <= IDW'(N_REQ - 1);
    end else if (ra_en) begin
      ra_vld    <= 1'b1;
      ra_addr_q <= i_ra_addr[ra_gid];
      ra_ptr    <= ra_gid;
    end else if (i_dramra_ack) begin
      ra_vld    <= 1'b0;
    end
  end

  assign o_dramra_rdy  = ra_vld;
  assign o_dramra_addr = ra_addr_q;

  // ---------------- in-order id FIFO and read return ----------------
  logic [IDW-1:0] id_mem [ID_DEPTH];
  logic [PW-1:0]  id_wptr;
  logic [PW-1:0]  id_rptr;
  logic           id_empty;
  logic [IDW-1:0] id_head;
  logic           rd_pop;

  assign id_empty = (rd_cnt == '0);
  assign id_head  = id_mem[id_rptr];

  always_comb begin
    o_rd_rdy = '0;
    if (i_dramrd_rdy && !id_empty) o_rd_rdy[id_head] = 1'b1;
  end

  assign o_dramrd_ack = !id_empty && i_rd_ack[id_head];
  assign o_rd_data    = i_dramrd_data;
  assign rd_pop       = o_dramrd_ack && i_dramrd_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      id_wptr <= '0;
      id_rptr <= '0;
      rd_cnt  <= '0;
      for (int i = 0; i < int'(ID_DEPTH); i++) id_mem[i] <= '0;
    end else begin
      if (ra_en) begin
        id_mem[id_wptr] <= ra_gid;
        id_wptr         <= id_wptr + PW'(1);
      end
      if (rd_pop) id_rptr <= id_rptr + PW'(1);
      case ({ra_en, rd_pop})
        2'b10:   rd_cnt <= rd_cnt + CW'(1);
        2'b01:   rd_cnt <= rd_cnt - CW'(1);
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A DRAM read beat with nothing outstanding is a protocol error.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_dramrd_rdy && id_empty))
        else $error("dram_port_arbiter: read data returned with no outstanding read");
    end
  end
`endif

  // ---------------- write arbiter ----------------
`ifdef DRAM_ARB_WRITE_EN
  logic           w_vld;
  logic [AW-1:0]  w_addr_q;
  logic [DW-1:0]  w_data_q;
  logic [IDW-1:0] w_ptr;
  logic           w_en;
  logic [IDW-1:0] w_gid;

  assign w_en = (!w_vld || i_dramw_ack) && (|i_w_rdy);

  rr_grant #(.N(N_REQ), .IDW(IDW)) u_w_rr (
    .req    (i_w_rdy),
    .en     (w_en),
    .ptr    (w_ptr),
    .gnt    (o_w_ack),
    .gnt_id (w_gid)
  );

  // The stage's requester id is w_ptr itself: the pointer only moves on a grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_vld    <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_ptr    <= IDW'(N_REQ - 1);
    end else if (w_en) begin
      w_vld    <= 1'b1;
      w_addr_q <= i_w_addr[w_gid];
      w_data_q <= i_w_data[w_gid];
      w_ptr    <= w_gid;
    end else if (i_dramw_ack) begin
      w_vld    <= 1'b0;
    end
  end

  assign o_dramw_rdy  = w_vld;
  assign o_dramw_addr = w_addr_q;
  assign o_dramw_data = w_data_q;
`else
  logic unused_w;
  assign unused_w     = ^{i_w_rdy, i_w_addr, i_w_data, i_dramw_ack};
  assign o_w_ack      = '0;
  assign o_dramw_rdy  = 1'b0;
  assign o_dramw_addr = '0;
  assign o_dramw_data = '0;
`endif

endmodule
